// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity codes and the bit-time divisor.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Rounded clocks per bit; the receiver uses the same divisor.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: wraps every CLKS_PER_BIT cycles; restart forces it to 0 on the next edge.
// tick flags the last cycle of a bit time, pre_tick the cycle before it; no backpressure.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  if (CLKS_PER_BIT < 2) begin : g_bad_div
    $error("uart_baud_tick: CLKS_PER_BIT must be at least 2");
  end

  logic [CW-1:0] cnt;

  // Wrapping at LAST keeps bit boundaries on exact multiples of CLKS_PER_BIT.
  always_ff @(posedge clk) begin
    if (reset || restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick     = (cnt == LAST);
  assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/uart_tx_framer.sv
// UART TX framer: byte accepted on tx_valid && tx_ready; start bit drives tx the cycle after accept.
// tx_ready stays low mid-frame (upstream holds its byte) and reopens in the last stop-bit cycle.
module uart_tx_framer #(
  parameter int CLK_HZ    = 60_000_000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  import uart_pkg::*;

  localparam int   CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam logic LAST_STOP    = (STOP_BITS == 2);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_framer: PARITY must be 0, 1 or 2");
  end

  uart_state_t state_q, state_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic        par_q, par_d;
  logic        tx_d, ready_d, busy_d;
  logic        accept, tick, pre_tick;

  assign accept = tx_valid && tx_ready;

  // Restarting on accept aligns the bit grid to the start bit; no further restarts within a frame.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (accept),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    par_d   = par_q;

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          sh_d = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_q == LAST_STOP) begin
            state_d = accept ? START : IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Byte and its parity are captured once; tx_data is ignored for the rest of the frame.
    if (accept) begin
      sh_d  = tx_data;
      par_d = (PARITY == PAR_EVEN) ? ^tx_data : ~^tx_data;
    end

    unique case (state_d)
      START:            tx_d = 1'b0;
      DATA:             tx_d = sh_d[0];
      uart_pkg::PARITY: tx_d = par_d;
      default:          tx_d = 1'b1;
    endcase

    // Ready for the whole of the final stop-bit cycle so frames can run back to back.
    ready_d = (state_d == IDLE) ||
              (state_q == STOP && stop_q == LAST_STOP && pre_tick);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      par_q    <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      par_q    <= par_d;
      tx       <= tx_d;
      tx_ready <= ready_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: four parameterisations share one clock and reset.
// Expected frames come from a bench-side frame builder via a scoreboard queue.
module tb_uart_tx_framer;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data [4];
  logic [3:0] tx_valid;
  logic [3:0] tx_ready;
  logic [3:0] tx;
  logic [3:0] busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-instance settings: 0 = 8N1, 1 = 8E2, 2 = 8O1 (all 16 clk/bit), 3 = defaults 8N1.
  int par_mode [4] = '{0, 2, 1, 0};
  int stops    [4] = '{1, 2, 1, 1};
  int cpb_of   [4] = '{16, 16, 16, 521};

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          cpb;
  } exp_t;

  typedef struct {
    int         d;
    logic [7:0] data;
    logic       bit9;
    int         len;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  uart_tx_framer #(.CLK_HZ(1600), .BAUD(100), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx(tx[0]), .busy(busy[0]));
  uart_tx_framer #(.CLK_HZ(1600), .BAUD(100), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx(tx[1]), .busy(busy[1]));
  uart_tx_framer #(.CLK_HZ(1600), .BAUD(100), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx(tx[2]), .busy(busy[2]));
  uart_tx_framer dut3 (
    .clk(clk), .reset(reset), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .tx(tx[3]), .busy(busy[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t frame_of(input int d, input logic [7:0] b);
    exp_t e;
    e.bits      = '1;
    e.bits[0]   = 1'b0;
    e.bits[8:1] = b;
    e.nbits     = 9 + stops[d];
    if (par_mode[d] != 0) begin
      e.bits[9] = (par_mode[d] == 2) ? ^b : ~^b;
      e.nbits++;
    end
    e.cpb = cpb_of[d];
    return e;
  endfunction

  task automatic wait_ready(input int d);
    int n = 0;
    while (tx_ready[d] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(tx_ready[d]), 1);
  endtask

  // Returns on the negedge just after the accept edge (cycle 0 of the frame).
  task automatic send(input int d, input logic [7:0] b, input bit push);
    tx_data[d]  = b;
    tx_valid[d] = 1'b1;
    wait_ready(d);
    if (push) sbq.push_back(frame_of(d, b));
    @(negedge clk);
    tx_valid[d] = 1'b0;
  endtask

  task automatic recv(input int d, input bit idle_after, input int exp_len,
                      output logic [11:0] got, output int wait_cyc);
    exp_t e;
    int n = 0, bad = 0, blen = 0, rdy = 0, rdy_at = -1, len;
    got = '1;
    while (tx[d] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    wait_cyc = n;
    chk("start_bit", 32'(tx[d]), 0);
    chk("scoreboard_has_entry", 32'(sbq.size() != 0), 1);
    if (sbq.size() == 0) return;
    e   = sbq.pop_front();
    len = e.nbits * e.cpb;
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      if (tx[d] !== e.bits[c / e.cpb]) bad++;
      if (busy[d] === 1'b1) blen++;
      if (tx_ready[d] === 1'b1) begin
        rdy++;
        rdy_at = c;
      end
      if (c % e.cpb == e.cpb / 2) got[c / e.cpb] = tx[d];
    end
    chk("frame_bit_errors", bad, 0);
    chk("ready_pulse_count", rdy, 1);
    chk("ready_pulse_cycle", rdy_at, len - 1);
    if (idle_after) begin
      @(negedge clk);
      if (busy[d] === 1'b1) blen++;
      chk("idle_after_frame", 32'({tx[d], tx_ready[d], busy[d]}), 6);
    end
    chk("busy_cycles", blen, exp_len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] got;
    int          w;
    int          bad;

    tbl = '{
      '{1, 8'h07, 1'b1, 192},
      '{2, 8'h07, 1'b0, 176},
      '{2, 8'h00, 1'b1, 176},
      '{1, 8'h00, 1'b0, 192},
      '{1, 8'hFF, 1'b0, 192},
      '{2, 8'h01, 1'b0, 176},
      '{2, 8'hFE, 1'b0, 176},
      '{0, 8'hA3, 1'b1, 160},
      '{0, 8'h80, 1'b1, 160},
      '{1, 8'h83, 1'b1, 192}
    };
    tx_valid = '0;
    foreach (tx_data[i]) tx_data[i] = 8'h00;

    // Reset: line idle, not ready, not busy.
    repeat (3) begin
      @(negedge clk);
      chk("reset_tx", 32'(tx), 32'hF);
      chk("reset_ready", 32'(tx_ready), 0);
      chk("reset_busy", 32'(busy), 0);
    end

    // Release with a byte already offered; ready rises one edge after release.
    tx_data[0]  = 8'h55;
    tx_valid[0] = 1'b1;
    reset       = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 32'(tx_ready[0]), 1);
    chk("tx_after_release", 32'(tx[0]), 1);
    send(0, 8'h55, 1);
    recv(0, 1, 160, got, w);
    chk("frame_0x55_bits", 32'(got[9:0]), 32'h2AA);

    // Back-to-back frames with tx_valid held high.
    fork
      begin
        tx_data[0]  = 8'hA3;
        tx_valid[0] = 1'b1;
        wait_ready(0);
        sbq.push_back(frame_of(0, 8'hA3));
        @(negedge clk);
        tx_data[0] = 8'h0F;
        wait_ready(0);
        sbq.push_back(frame_of(0, 8'h0F));
        @(negedge clk);
        tx_valid[0] = 1'b0;
      end
      begin
        logic [11:0] g2;
        int          w2;
        recv(0, 0, 160, g2, w2);
        chk("b2b_first_data", 32'(g2[8:1]), 32'hA3);
        recv(0, 1, 160, g2, w2);
        chk("b2b_gap_cycles", w2, 1);
        chk("b2b_second_data", 32'(g2[8:1]), 32'h0F);
      end
    join

    // Table of parity / stop-bit variants.
    foreach (tbl[i]) begin
      send(tbl[i].d, tbl[i].data, 1);
      recv(tbl[i].d, 1, tbl[i].len, got, w);
      chk($sformatf("vec%0d_data", i), 32'(got[8:1]), 32'(tbl[i].data));
      chk($sformatf("vec%0d_bit9", i), 32'(got[9]), 32'(tbl[i].bit9));
      if (tbl[i].d == 1) chk($sformatf("vec%0d_stop_tail", i), 32'(got[11:10]), 3);
    end

    // One-cycle reset at cycle 50 of a frame aborts it.
    send(0, 8'h00, 0);
    repeat (50) @(negedge clk);
    chk("midreset_pre_tx", 32'(tx[0]), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_tx", 32'(tx[0]), 1);
    chk("midreset_busy", 32'(busy[0]), 0);
    chk("midreset_ready", 32'(tx_ready[0]), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_ready_back", 32'(tx_ready[0]), 1);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    chk("midreset_line_quiet", bad, 0);

    // tx_valid pulsed while busy and tx_data changed after accept.
    send(0, 8'h3C, 1);
    tx_data[0] = 8'hC3;
    fork
      recv(0, 1, 160, got, w);
      begin
        repeat (40) @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hFF;
        repeat (5) @(negedge clk);
        tx_valid[0] = 1'b0;
        tx_data[0]  = 8'h5A;
      end
    join
    chk("latched_data", 32'(got[8:1]), 32'h3C);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    chk("no_extra_frame", bad, 0);

    // Default parameters: 521 clk/bit, 5210-cycle 8N1 frame.
    send(3, 8'hC5, 1);
    recv(3, 1, 5210, got, w);
    chk("default_data", 32'(got[8:1]), 32'hC5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
